// File: rtl/pc_fetch_if.sv
`default_nettype none
// ============================================================================
// pc_fetch_if : instruction-memory fetch request/acknowledge handshake
// Revision    : 1.0
// ============================================================================
interface pc_fetch_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ack;

  modport master (
    output fetch_req,
    output fetch_addr,
    input  fetch_ack
  );

  modport slave (
    input  fetch_req,
    input  fetch_addr,
    output fetch_ack
  );
endinterface
`default_nettype wire

// File: rtl/pc_fetch.sv
`default_nettype none
// ============================================================================
// pc_fetch : IF-stage fetch-address generator with prioritised redirect latch
// Revision : 1.0
// ============================================================================
module pc_fetch #(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC  = ADDR_W'(32'hbfc00000),
  parameter int unsigned       STEP       = 4,
  parameter int unsigned       ALIGN_BITS = 2
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              stall,
  input  wire logic              debug_reset,
  input  wire logic              exc_valid,
  input  wire logic [ADDR_W-1:0] exc_addr,
  input  wire logic              dbg_valid,
  input  wire logic [ADDR_W-1:0] dbg_addr,
  input  wire logic              br_valid,
  input  wire logic [ADDR_W-1:0] br_addr,
  pc_fetch_if.master             imem,
  output logic [ADDR_W-1:0]      pc_addr,
  output logic                   pc_valid,
  output logic                   redirect_pend
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << ALIGN_BITS) - ADDR_W'(1));
  localparam logic [ADDR_W-1:0] STEP_W     = ADDR_W'(STEP);

  localparam logic [1:0] PRIO_BR   = 2'd0;
  localparam logic [1:0] PRIO_DBG  = 2'd1;
  localparam logic [1:0] PRIO_EXC  = 2'd2;
  localparam logic [1:0] PRIO_DRST = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_W-1:0] pc_addr_q, pc_addr_d;
  logic              pc_valid_q, pc_valid_d;
  logic              pend_valid_q, pend_valid_d;
  logic [1:0]        pend_prio_q, pend_prio_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;

  logic              in_valid;
  logic [1:0]        in_prio;
  logic [ADDR_W-1:0] in_addr;
  logic              win_valid;
  logic [1:0]        win_prio;
  logic [ADDR_W-1:0] win_addr;
  logic              ack;
  logic              squash;

  // Highest-priority redirect arriving this cycle, target already aligned.
  always_comb begin
    in_valid = 1'b1;
    in_prio  = PRIO_BR;
    in_addr  = '0;
    if (debug_reset) begin
      in_prio = PRIO_DRST;
      in_addr = RESET_VEC;
    end else if (exc_valid) begin
      in_prio = PRIO_EXC;
      in_addr = exc_addr & ALIGN_MASK;
    end else if (dbg_valid) begin
      in_prio = PRIO_DBG;
      in_addr = dbg_addr & ALIGN_MASK;
    end else if (br_valid) begin
      in_prio = PRIO_BR;
      in_addr = br_addr & ALIGN_MASK;
    end else begin
      in_valid = 1'b0;
    end
  end

  // Incoming redirect beats the latch on a priority tie.
  always_comb begin
    win_valid = in_valid | pend_valid_q;
    win_prio  = pend_prio_q;
    win_addr  = pend_addr_q;
    if (in_valid && (!pend_valid_q || (in_prio >= pend_prio_q))) begin
      win_prio = in_prio;
      win_addr = in_addr;
    end else if (!pend_valid_q) begin
      win_prio = PRIO_BR;
      win_addr = '0;
    end
  end

  assign ack    = (state_q == S_REQ) && imem.fetch_ack;
  // Branches leave the in-flight fetch alive as its delay slot.
  assign squash = debug_reset | exc_valid | dbg_valid
                | (pend_valid_q && (pend_prio_q != PRIO_BR));

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    pc_addr_d    = pc_addr_q;
    pc_valid_d   = 1'b0;
    pend_valid_d = 1'b0;
    pend_prio_d  = PRIO_BR;
    pend_addr_d  = '0;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (win_valid) fetch_addr_d = win_addr;
      end
      S_REQ: begin
        if (ack) begin
          pc_addr_d    = fetch_addr_q;
          pc_valid_d   = !squash;
          fetch_addr_d = win_valid ? win_addr : (fetch_addr_q + STEP_W);
          state_d      = stall ? S_HOLD : S_REQ;
        end else begin
          pend_valid_d = win_valid;
          pend_prio_d  = win_prio;
          pend_addr_d  = win_addr;
        end
      end
      S_HOLD: begin
        if (win_valid) fetch_addr_d = win_addr;
        if (!stall) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      fetch_addr_q <= RESET_VEC;
      pc_addr_q    <= RESET_VEC;
      pc_valid_q   <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_prio_q  <= PRIO_BR;
      pend_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      pc_addr_q    <= pc_addr_d;
      pc_valid_q   <= pc_valid_d;
      pend_valid_q <= pend_valid_d;
      pend_prio_q  <= pend_prio_d;
      pend_addr_q  <= pend_addr_d;
    end
  end

  assign imem.fetch_req  = (state_q == S_REQ);
  assign imem.fetch_addr = fetch_addr_q;
  assign pc_addr         = pc_addr_q;
  assign pc_valid        = pc_valid_q;
  assign redirect_pend   = pend_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch.sv
`default_nettype none
// ============================================================================
// tb_pc_fetch : directed and randomised checks of pc_fetch against a model
// Revision    : 1.0
// ============================================================================
module tb_pc_fetch;

  localparam logic [31:0] RV   = 32'hbfc00000;
  localparam logic [31:0] MASK = 32'hffff_fffc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, debug_reset, exc_valid, dbg_valid, br_valid;
  logic [31:0] exc_addr, dbg_addr, br_addr;
  logic [31:0] pc_addr;
  logic        pc_valid, redirect_pend;

  logic        rst16, zero1;
  logic [15:0] zero16, pc_addr16;
  logic        pc_valid16, redirect_pend16;

  int n_total = 0;
  int n_pass  = 0;

  pc_fetch_if #(.ADDR_W(32)) imem ();
  pc_fetch_if #(.ADDR_W(16)) imem16 ();

  pc_fetch #(.ADDR_W(32), .RESET_VEC(32'hbfc00000), .STEP(4), .ALIGN_BITS(2)) dut (
    .clk(clk), .rst(rst), .stall(stall), .debug_reset(debug_reset),
    .exc_valid(exc_valid), .exc_addr(exc_addr),
    .dbg_valid(dbg_valid), .dbg_addr(dbg_addr),
    .br_valid(br_valid), .br_addr(br_addr),
    .imem(imem),
    .pc_addr(pc_addr), .pc_valid(pc_valid), .redirect_pend(redirect_pend)
  );

  pc_fetch #(.ADDR_W(16), .RESET_VEC(16'hfffc), .STEP(4), .ALIGN_BITS(2)) dut16 (
    .clk(clk), .rst(rst16), .stall(zero1), .debug_reset(zero1),
    .exc_valid(zero1), .exc_addr(zero16),
    .dbg_valid(zero1), .dbg_addr(zero16),
    .br_valid(zero1), .br_addr(zero16),
    .imem(imem16),
    .pc_addr(pc_addr16), .pc_valid(pc_valid16), .redirect_pend(redirect_pend16)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: outputs after each edge, derived from the redirect rules.
  bit          m_known = 0;
  bit          m_fresh, m_req, m_pcv, m_pv;
  int          m_pp;
  logic [31:0] m_addr, m_pc, m_pa;

  always @(posedge clk) begin : model
    bit          cv [4];
    logic [31:0] ca [4];
    bit          iv, wv, ackd;
    int          ip, wp;
    logic [31:0] ia, wa;
    if (rst) begin
      m_known = 1; m_fresh = 1; m_req = 0; m_pcv = 0; m_pv = 0; m_pp = 0;
      m_addr = RV; m_pc = RV; m_pa = '0;
    end else if (m_known) begin
      cv = '{debug_reset, exc_valid, dbg_valid, br_valid};
      ca = '{RV, exc_addr & MASK, dbg_addr & MASK, br_addr & MASK};
      iv = 0; ip = 0; ia = '0;
      for (int i = 0; i < 4; i++)
        if (cv[i] && !iv) begin iv = 1; ip = 3 - i; ia = ca[i]; end
      wv = iv; wp = ip; wa = ia;
      if (m_pv && (!iv || ip < m_pp)) begin wv = 1; wp = m_pp; wa = m_pa; end
      ackd  = m_req && imem.fetch_ack;
      m_pcv = 0;
      if (m_req && !ackd) begin
        m_pv = wv; m_pp = wp; m_pa = wa;
      end else begin
        if (ackd) begin
          m_pc   = m_addr;
          m_pcv  = !(debug_reset || exc_valid || dbg_valid || (m_pv && m_pp >= 1));
          m_addr = wv ? wa : m_addr + 32'd4;
          m_req  = !stall;
        end else begin
          if (wv) m_addr = wa;
          m_req = m_fresh || !stall;
        end
        m_pv = 0; m_fresh = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      chk("model fetch_req",     {31'd0, imem.fetch_req}, {31'd0, m_req});
      chk("model fetch_addr",    imem.fetch_addr,         m_addr);
      chk("model pc_addr",       pc_addr,                 m_pc);
      chk("model pc_valid",      {31'd0, pc_valid},       {31'd0, m_pcv});
      chk("model redirect_pend", {31'd0, redirect_pend},  {31'd0, m_pv});
    end
  end

  initial begin
    rst = 1; stall = 0; debug_reset = 0; exc_valid = 0; dbg_valid = 0; br_valid = 0;
    exc_addr = '0; dbg_addr = '0; br_addr = '0; imem.fetch_ack = 0;
    rst16 = 1; zero1 = 0; zero16 = '0; imem16.fetch_ack = 1;
    @(negedge clk);
    cyc();
    chk("rst fetch_req",  {31'd0, imem.fetch_req}, 32'd0);
    chk("rst fetch_addr", imem.fetch_addr, 32'hbfc00000);
    chk("rst pc_addr",    pc_addr, 32'hbfc00000);
    chk("rst pc_valid",   {31'd0, pc_valid}, 32'd0);
    chk("rst pend",       {31'd0, redirect_pend}, 32'd0);
    rst = 0; rst16 = 0; imem.fetch_ack = 1;
    cyc();
    chk("first req",        {31'd0, imem.fetch_req}, 32'd1);
    chk("seq addr0",        imem.fetch_addr, 32'hbfc00000);
    chk("wrap16 addr0",     {16'd0, imem16.fetch_addr}, 32'h0000fffc);
    cyc();
    chk("seq addr1",        imem.fetch_addr, 32'hbfc00004);
    chk("seq pc_valid",     {31'd0, pc_valid}, 32'd1);
    chk("wrap16 addr1",     {16'd0, imem16.fetch_addr}, 32'h00000000);
    chk("wrap16 pc_addr",   {16'd0, pc_addr16}, 32'h0000fffc);
    cyc();
    chk("seq addr2",        imem.fetch_addr, 32'hbfc00008);
    chk("wrap16 addr2",     {16'd0, imem16.fetch_addr}, 32'h00000004);

    // Branch latched while memory is slow; delay slot still completes.
    imem.fetch_ack = 0; br_valid = 1; br_addr = 32'h80000103;
    cyc();
    br_valid = 0;
    chk("br pend",          {31'd0, redirect_pend}, 32'd1);
    chk("br addr hold",     imem.fetch_addr, 32'hbfc00008);
    cyc(); cyc();
    chk("br pend held",     {31'd0, redirect_pend}, 32'd1);
    imem.fetch_ack = 1;
    cyc();
    chk("br slot valid",    {31'd0, pc_valid}, 32'd1);
    chk("br slot pc",       pc_addr, 32'hbfc00008);
    chk("br target",        imem.fetch_addr, 32'h80000100);
    chk("br pend clear",    {31'd0, redirect_pend}, 32'd0);

    // Exception overrides pending branch and resists a later branch.
    imem.fetch_ack = 0; br_valid = 1; br_addr = 32'h80000200;
    cyc();
    br_valid = 0; exc_valid = 1; exc_addr = 32'h80000180;
    cyc();
    exc_valid = 0; br_valid = 1; br_addr = 32'h80000300;
    cyc();
    br_valid = 0; imem.fetch_ack = 1;
    cyc();
    chk("exc squash",       {31'd0, pc_valid}, 32'd0);
    chk("exc target",       imem.fetch_addr, 32'h80000180);

    // Stall on ack, debugger redirect while held.
    stall = 1;
    cyc();
    chk("hold req",         {31'd0, imem.fetch_req}, 32'd0);
    chk("hold pc",          pc_addr, 32'h80000180);
    imem.fetch_ack = 0; dbg_valid = 1; dbg_addr = 32'h00001002;
    cyc();
    dbg_valid = 0; stall = 0;
    chk("hold dbg addr",    imem.fetch_addr, 32'h00001000);
    cyc();
    chk("hold release req", {31'd0, imem.fetch_req}, 32'd1);
    chk("hold release addr", imem.fetch_addr, 32'h00001000);

    // debug_reset beats exception on an ack cycle.
    imem.fetch_ack = 1; debug_reset = 1; exc_valid = 1; exc_addr = 32'h80000180;
    cyc();
    debug_reset = 0; exc_valid = 0;
    chk("drst addr",        imem.fetch_addr, 32'hbfc00000);
    chk("drst squash",      {31'd0, pc_valid}, 32'd0);

    // Reset mid-fetch; following ack is ignored.
    rst = 1; imem.fetch_ack = 0;
    cyc();
    chk("rst mid req",      {31'd0, imem.fetch_req}, 32'd0);
    chk("rst mid addr",     imem.fetch_addr, 32'hbfc00000);
    rst = 0; imem.fetch_ack = 1;
    cyc();
    chk("post rst addr",    imem.fetch_addr, 32'hbfc00000);
    chk("post rst valid",   {31'd0, pc_valid}, 32'd0);

    for (int n = 0; n < 3000; n++) begin
      rst            = ($urandom_range(0, 255) == 0);
      stall          = ($urandom_range(0, 3) == 0);
      imem.fetch_ack = $urandom_range(0, 1) == 1;
      debug_reset    = ($urandom_range(0, 31) == 0);
      exc_valid      = ($urandom_range(0, 7) == 0);
      dbg_valid      = ($urandom_range(0, 7) == 0);
      br_valid       = ($urandom_range(0, 5) == 0);
      exc_addr       = $urandom;
      dbg_addr       = $urandom;
      br_addr        = $urandom;
      cyc();
    end
    rst = 0; stall = 0; debug_reset = 0; exc_valid = 0; dbg_valid = 0; br_valid = 0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
